// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller for the dual-clock FIFO RAM (clk_we domain).
// Drives the RAM write port, publishes a Gray write pointer, and derives full/level from the synchronised read pointer.
module fifo_wr_ctrl #(
  parameter int WD        = 32,
  parameter int MEM_SIZE  = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                rst,
  input  logic                clk_we,
  input  logic                wr_valid,
  input  logic [WD-1:0]       wr_data,
  output logic                wr_ready,
  output logic                we,
  output logic [MEM_SIZE-1:0] we_point,
  output logic [WD-1:0]       wdata,
  input  logic [MEM_SIZE:0]   re_ptr_gray,
  output logic [MEM_SIZE:0]   we_ptr_gray,
  output logic                full,
  output logic                almost_full,
  output logic [MEM_SIZE:0]   wr_level,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int PW = MEM_SIZE + 1;
  localparam logic [PW-1:0] DEPTH    = PW'(1) << MEM_SIZE;
  localparam logic [PW-1:0] AF_LEVEL = DEPTH - PW'(AF_MARGIN);

  logic [PW-1:0] wptr_bin_reg,  wptr_bin_next;
  logic [PW-1:0] wptr_gray_reg, wptr_gray_next;
  logic [PW-1:0] rq1_reg, rq2_reg;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_pattern;
  logic          overflow_reg, overflow_next;
  logic          push;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_gray2bin
      assign rbin[gi] = ^rq2_reg[PW-1:gi];
    end
  endgenerate

  // Full when the write pointer is exactly one lap ahead of the read pointer.
  generate
    if (MEM_SIZE == 1) begin : g_full_small
      assign full_pattern = ~rq2_reg;
    end else begin : g_full_wide
      assign full_pattern = {~rq2_reg[MEM_SIZE:MEM_SIZE-1], rq2_reg[MEM_SIZE-2:0]};
    end
  endgenerate

  always_comb begin
    push           = wr_valid & ~full;
    wptr_bin_next  = wptr_bin_reg + PW'(push);
    wptr_gray_next = wptr_bin_next ^ (wptr_bin_next >> 1);
    // A fresh overflow event takes priority over a coincident clear.
    overflow_next  = (wr_valid & full) | (overflow_reg & ~clr_overflow);
  end

  always_ff @(posedge clk_we or negedge rst) begin
    if (!rst) begin
      wptr_bin_reg  <= '0;
      wptr_gray_reg <= '0;
      rq1_reg       <= '0;
      rq2_reg       <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      wptr_bin_reg  <= wptr_bin_next;
      wptr_gray_reg <= wptr_gray_next;
      rq1_reg       <= re_ptr_gray;
      rq2_reg       <= rq1_reg;
      overflow_reg  <= overflow_next;
    end
  end

  assign full        = (wptr_gray_reg == full_pattern);
  assign wr_ready    = ~full;
  assign we          = push;
  assign we_point    = wptr_bin_reg[MEM_SIZE-1:0];
  assign wdata       = wr_data;
  assign we_ptr_gray = wptr_gray_reg;
  assign wr_level    = wptr_bin_reg - rbin;
  assign almost_full = (wr_level >= AF_LEVEL);
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl at MEM_SIZE=4 (DEPTH=16), AF_MARGIN=2, WD=32.
// RAM writes are checked against a scoreboard of expected {address, data} entries.
module tb_fifo_wr_ctrl;
  localparam int WD = 32;
  localparam int MS = 4;

  logic          clk_we = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic [WD-1:0] wr_data = '0;
  logic          clr_overflow = 1'b0;
  logic [MS:0]   re_ptr_gray = '0;
  logic          wr_ready, we, full, almost_full, overflow;
  logic [MS-1:0] we_point;
  logic [WD-1:0] wdata;
  logic [MS:0]   we_ptr_gray, wr_level;

  fifo_wr_ctrl #(.WD(WD), .MEM_SIZE(MS), .AF_MARGIN(2)) dut (
    .rst(rst), .clk_we(clk_we), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .we(we), .we_point(we_point), .wdata(wdata),
    .re_ptr_gray(re_ptr_gray), .we_ptr_gray(we_ptr_gray), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #5 clk_we = ~clk_we;

  typedef struct {
    logic [MS-1:0] addr;
    logic [WD-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [MS:0] w_model = '0;
  logic [MS:0] r_model = '0;
  logic [MS:0] r_pipe[3];

  function automatic logic [MS:0] b2g(input logic [MS:0] b);
    return b ^ (b >> 1);
  endfunction

  // Scoreboard: every RAM write must match the oldest expected entry.
  always @(negedge clk_we) begin
    if (rst && we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_write: got we_point=%0d wdata=%h, required no write", we_point, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (we_point !== mon_e.addr || wdata !== mon_e.data) begin
          miscompares++;
          $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                   we_point, wdata, mon_e.addr, mon_e.data);
        end else
          $display("write addr=%0d data=%h ok", we_point, wdata);
      end
    end
  end

  // One transaction slot: inputs change just after a posedge, outputs are observed at the negedge.
  task automatic slot(input logic v, input logic [WD-1:0] d, input logic clr, input logic [MS:0] rg);
    @(posedge clk_we);
    #1;
    wr_valid     = v;
    wr_data      = d;
    clr_overflow = clr;
    re_ptr_gray  = rg;
    @(negedge clk_we);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk_we);
    #1 rst = 1'b1;
    @(negedge clk_we);
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %b required 1", wr_ready); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b required 0", full); end
    vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full: got %b required 0", almost_full); end
    vectors++; if (wr_level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d required 0", wr_level); end
    vectors++; if (we_ptr_gray !== 5'd0) begin miscompares++; $display("FAIL reset_gray: got %b required 00000", we_ptr_gray); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    $display("reset idle checked");
  endtask

  task automatic test_fill();
    logic [WD-1:0] d;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      exp_q.push_back('{addr: w_model[MS-1:0], data: d});
      slot(1'b1, d, 1'b0, 5'd0);
      vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL fill_we[%0d]: got %b required 1", i, we); end
      vectors++; if (wr_level !== 5'(i)) begin miscompares++; $display("FAIL fill_level[%0d]: got %0d required %0d", i, wr_level, i); end
      vectors++; if (almost_full !== (i >= 14)) begin miscompares++; $display("FAIL fill_af[%0d]: got %b required %b", i, almost_full, i >= 14); end
      vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL fill_full[%0d]: got %b required 0", i, full); end
      w_model++;
    end
    slot(1'b0, '0, 1'b0, 5'd0);
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full_end: got %b required 1", full); end
    vectors++; if (almost_full !== 1'b1) begin miscompares++; $display("FAIL fill_af_end: got %b required 1", almost_full); end
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_end: got %b required 0", wr_ready); end
    vectors++; if (wr_level !== 5'd16) begin miscompares++; $display("FAIL fill_level_end: got %0d required 16", wr_level); end
    vectors++; if (we_ptr_gray !== 5'b11000) begin miscompares++; $display("FAIL fill_gray_end: got %b required 11000", we_ptr_gray); end
    $display("fill to full checked");
  endtask

  task automatic test_overflow();
    slot(1'b1, 32'hDEADBEEF, 1'b0, 5'd0);
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL ovf_we: got %b required 0", we); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_pre: got %b required 0", overflow); end
    slot(1'b0, '0, 1'b0, 5'd0);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b required 1", overflow); end
    vectors++; if (we_ptr_gray !== 5'b11000) begin miscompares++; $display("FAIL ovf_gray: got %b required 11000", we_ptr_gray); end
    vectors++; if (wr_level !== 5'd16) begin miscompares++; $display("FAIL ovf_level: got %0d required 16", wr_level); end
    slot(1'b0, '0, 1'b1, 5'd0);
    slot(1'b0, '0, 1'b0, 5'd0);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b required 0", overflow); end
    slot(1'b1, 32'hDEADBEEF, 1'b1, 5'd0);
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL ovf_we2: got %b required 0", we); end
    slot(1'b0, '0, 1'b0, 5'd0);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set_wins: got %b required 1", overflow); end
    slot(1'b0, '0, 1'b1, 5'd0);
    slot(1'b0, '0, 1'b0, 5'd0);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear2: got %b required 0", overflow); end
    $display("overflow set/clear checked");
  endtask

  task automatic test_read_release();
    logic [WD-1:0] d;
    slot(1'b0, '0, 1'b0, 5'b00001);
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL rel_full_e0: got %b required 1", full); end
    slot(1'b0, '0, 1'b0, 5'b00001);
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL rel_full_e1: got %b required 1", full); end
    slot(1'b0, '0, 1'b0, 5'b00001);
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rel_full_e2: got %b required 0", full); end
    vectors++; if (wr_level !== 5'd15) begin miscompares++; $display("FAIL rel_level: got %0d required 15", wr_level); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL rel_ready: got %b required 1", wr_ready); end
    d = $urandom;
    exp_q.push_back('{addr: w_model[MS-1:0], data: d});
    slot(1'b1, d, 1'b0, 5'b00001);
    vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL rel_push_we: got %b required 1", we); end
    w_model++;
    slot(1'b0, '0, 1'b0, 5'b00001);
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL rel_refull: got %b required 1", full); end
    vectors++; if (we_ptr_gray !== b2g(w_model)) begin miscompares++; $display("FAIL rel_gray: got %b required %b", we_ptr_gray, b2g(w_model)); end
    $display("read release checked");
  endtask

  // Advances the reader by one Gray step per slot; the writer sees it two edges later.
  task automatic stream_slot(input logic v, input logic [WD-1:0] d, input logic adv_r);
    if (adv_r) r_model++;
    r_pipe[2] = r_pipe[1];
    r_pipe[1] = r_pipe[0];
    r_pipe[0] = r_model;
    if (v) exp_q.push_back('{addr: w_model[MS-1:0], data: d});
    slot(v, d, 1'b0, b2g(r_model));
    vectors++;
    if (wr_level !== 5'(w_model - r_pipe[2])) begin
      miscompares++;
      $display("FAIL stream_level: got %0d required %0d", wr_level, 5'(w_model - r_pipe[2]));
    end
  endtask

  task automatic test_stream();
    logic [MS:0] prev_gray;
    int          toggles;
    r_model = 5'd1;
    for (int i = 0; i < 3; i++) r_pipe[i] = r_model;
    for (int i = 0; i < 12; i++) stream_slot(1'b0, '0, 1'b1);
    prev_gray = we_ptr_gray;
    toggles = 0;
    for (int i = 0; i < 40; i++) begin
      stream_slot(1'b1, $urandom, 1'b1);
      vectors++; if (we !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL stream_push[%0d]: got we=%b full=%b required we=1 full=0", i, we, full); end
      if (i > 0) begin
        vectors++;
        if ($countones(we_ptr_gray ^ prev_gray) != 1) begin
          miscompares++;
          $display("FAIL stream_gray_step[%0d]: got %b after %b, required one bit change", i, we_ptr_gray, prev_gray);
        end
      end
      if (we_ptr_gray[MS] != prev_gray[MS]) toggles++;
      prev_gray = we_ptr_gray;
      w_model++;
    end
    stream_slot(1'b0, '0, 1'b0);
    vectors++; if (we_ptr_gray !== b2g(w_model)) begin miscompares++; $display("FAIL stream_gray_end: got %b required %b", we_ptr_gray, b2g(w_model)); end
    if (we_ptr_gray[MS] != prev_gray[MS]) toggles++;
    vectors++; if (toggles != 2) begin miscompares++; $display("FAIL stream_wrap_toggles: got %0d required 2", toggles); end
    $display("stream of 40 words checked");
  endtask

  task automatic test_reset_mid();
    while (r_model != w_model) stream_slot(1'b0, '0, 1'b1);
    repeat (3) stream_slot(1'b0, '0, 1'b0);
    vectors++; if (wr_level !== 5'd0) begin miscompares++; $display("FAIL mid_empty: got %0d required 0", wr_level); end
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back('{addr: w_model[MS-1:0], data: $urandom});
      slot(1'b1, exp_q[exp_q.size()-1].data, 1'b0, b2g(r_model));
      w_model++;
    end
    @(posedge clk_we);
    #1 wr_valid = 1'b0;
    vectors++; if (wr_level !== 5'd9) begin miscompares++; $display("FAIL mid_level_9: got %0d required 9", wr_level); end
    #1 rst = 1'b0;
    re_ptr_gray = '0;
    #1;
    vectors++; if (wr_level !== 5'd0) begin miscompares++; $display("FAIL mid_rst_level: got %0d required 0", wr_level); end
    vectors++; if (we_ptr_gray !== 5'd0) begin miscompares++; $display("FAIL mid_rst_gray: got %b required 00000", we_ptr_gray); end
    vectors++; if (we_point !== 4'd0) begin miscompares++; $display("FAIL mid_rst_point: got %0d required 0", we_point); end
    vectors++; if (full !== 1'b0 || almost_full !== 1'b0 || wr_ready !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_flags: got full=%b af=%b ready=%b ovf=%b required 0 0 1 0", full, almost_full, wr_ready, overflow);
    end
    repeat (2) @(posedge clk_we);
    #1 rst = 1'b1;
    $display("reset mid-operation checked");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_stream();
    test_reset_mid();
    @(negedge clk_we);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending writes, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
